sram_req_bridge: RTL
====================

SRAM_REQ_BRIDGE -- requirements
Module: sram_req_bridge

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, SRAM word width in bits (multiple of 8).
REQ-002 SHALL have parameter NUM_WORDS, default 1024, SRAM depth in words.
REQ-003 SHALL have parameter ADDR_WIDTH, default 32, request byte-address width.
REQ-004 SHALL have parameter BASE_ADDR, default 32'h0000_0000, byte address of SRAM word 0.
REQ-005 Clocking/reset: one clock; reset is asynchronous and active-low.
REQ-006 clk_i  input  1  clock, all state on rising edge.
REQ-007 rst_ni  input  1  asynchronous active-low reset.
REQ-008 req_valid_i  input  1  request valid.
REQ-009 req_ready_o  output  1  request accepted when valid and ready are both high.
REQ-010 req_we_i  input  1  1 = write, 0 = read.
REQ-011 req_addr_i  input  ADDR_WIDTH  byte address.
REQ-012 req_wdata_i  input  DATA_WIDTH  write data.
REQ-013 req_be_i  input  DATA_WIDTH/8  byte enables.
REQ-014 rsp_valid_o  output  1  response valid.
REQ-015 rsp_ready_i  input  1  response consumed when valid and ready are both high.
REQ-016 rsp_rdata_o  output  DATA_WIDTH  read data (0 for writes and errors).
REQ-017 rsp_err_o  output  1  request address was out of range.
REQ-018 sram_req_o, sram_we_o  output  1 each  SRAM port strobe and write enable.
REQ-019 sram_addr_o  output  $clog2(NUM_WORDS)  SRAM word index.
REQ-020 sram_wdata_o  output  DATA_WIDTH; sram_be_o  output  DATA_WIDTH/8.
REQ-021 sram_rdata_i  input  DATA_WIDTH  SRAM read data, valid one cycle after a read strobe.

Function
REQ-022 Word index SHALL be (req_addr_i - BASE_ADDR) >> $clog2(DATA_WIDTH/8); low byte-offset bits ignored.
REQ-023 Request SHALL be in range iff req_addr_i >= BASE_ADDR and word index < NUM_WORDS.
REQ-024 On an in-range accept in cycle N, sram_req_o SHALL be 1 in cycle N, with sram_we_o/addr/wdata/be driven combinationally from the request.
REQ-025 sram_req_o SHALL be 0 in every cycle without an in-range accept; sram_we_o and sram_be_o SHALL be 0 when sram_req_o is 0.
REQ-026 An out-of-range accept SHALL NOT strobe the SRAM.
REQ-027 Single in-flight register SHALL capture {valid, we, err} at accept; in cycle N+1 the response SHALL be pushed into a 2-entry response FIFO.
REQ-028 Pushed rdata SHALL be sram_rdata_i for in-range reads, else 0; err SHALL be 1 only for out-of-range.
REQ-029 rsp_valid_o SHALL be 1 iff the FIFO is non-empty; head entry SHALL be held stable until popped; earliest response is cycle N+2.
REQ-030 req_ready_o SHALL be 1 iff (fifo_count + inflight - pop_this_cycle) < 2, where pop = rsp_valid_o & rsp_ready_i; the combinational rsp_ready_i->req_ready_o path is intended.
REQ-031 With rsp_ready_i held high, sustained throughput SHALL be one request per cycle.
REQ-032 Simultaneous push and pop SHALL leave the count unchanged; FIFO SHALL never overflow or underflow.
REQ-033 Responses SHALL be returned in request order, exactly one per accepted request (writes included).
REQ-034 req_ready_o SHALL NOT depend on req_valid_i.

Reset
REQ-035 While rst_ni is low: req_ready_o=0, rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0, sram_req_o=0, sram_we_o=0, sram_be_o=0.
REQ-036 Reset assertion mid-operation SHALL discard the in-flight entry and FIFO contents; no stale response SHALL appear after release.
REQ-037 First accept SHALL be possible in the first cycle after rst_ni rises.

Verification
REQ-038 Write addr BASE+0x10, wdata 0xDEADBEEF, be 0xF, then read BASE+0x10 -> sram_addr_o=4 on both; read rsp_rdata_o=0xDEADBEEF, err=0; write rsp rdata=0.
REQ-039 Back-to-back 8 reads, rsp_ready_i=1 -> req_ready_o stays 1; 8 in-order responses at cycles N+2..N+9.
REQ-040 rsp_ready_i=0, issue 3 reads -> first two accepted, req_ready_o=0 on third; raise rsp_ready_i -> third accepted in that same cycle.
REQ-041 Read at BASE+4*NUM_WORDS and at BASE-4 -> sram_req_o stays 0; responses err=1, rdata=0.
REQ-042 Partial write be=0x2 data 0x0000AB00 over 0x11223344 -> readback 0x1122AB44.
REQ-043 Assert rst_ni low with 2 responses queued -> rsp_valid_o=0 immediately; after release no response until a new request.

Source files
------------

// File: rtl/sram_req_bridge.sv
// sram_req_bridge: valid/ready request port to a single-port SRAM with a
// one-cycle read latency. Responses come back in request order through a
// 2-entry FIFO, one response per accepted request.
//
// Ports:
//   clk_i, rst_ni                  clock, asynchronous active-low reset
//   req_valid_i / req_ready_o      request handshake
//   req_we_i, req_addr_i           write flag, byte address
//   req_wdata_i, req_be_i          write data, byte enables
//   rsp_valid_o / rsp_ready_i      response handshake
//   rsp_rdata_o, rsp_err_o         read data (0 for writes/errors), range error
//   sram_req_o, sram_we_o          SRAM strobe and write enable
//   sram_addr_o                    SRAM word index
//   sram_wdata_o, sram_be_o        SRAM write data and byte enables
//   sram_rdata_i                   SRAM read data, one cycle after a read strobe
module sram_req_bridge #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_WORDS  = 1024,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          req_valid_i,
    output logic                          req_ready_o,
    input  logic                          req_we_i,
    input  logic [ADDR_WIDTH-1:0]         req_addr_i,
    input  logic [DATA_WIDTH-1:0]         req_wdata_i,
    input  logic [DATA_WIDTH/8-1:0]       req_be_i,
    output logic                          rsp_valid_o,
    input  logic                          rsp_ready_i,
    output logic [DATA_WIDTH-1:0]         rsp_rdata_o,
    output logic                          rsp_err_o,
    output logic                          sram_req_o,
    output logic                          sram_we_o,
    output logic [$clog2(NUM_WORDS)-1:0]  sram_addr_o,
    output logic [DATA_WIDTH-1:0]         sram_wdata_o,
    output logic [DATA_WIDTH/8-1:0]       sram_be_o,
    input  logic [DATA_WIDTH-1:0]         sram_rdata_i
);

    localparam int unsigned BE_W  = DATA_WIDTH / 8;
    localparam int unsigned OFF_W = $clog2(BE_W);
    localparam int unsigned IDX_W = $clog2(NUM_WORDS);
    localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);

    typedef struct packed {
        logic                  err;
        logic [DATA_WIDTH-1:0] rdata;
    } rsp_t;

    // Address decode
    logic [ADDR_WIDTH-1:0] offset;
    logic [ADDR_WIDTH-1:0] word;
    logic                  in_range;

    assign offset   = req_addr_i - BASE;
    assign word     = offset >> OFF_W;
    assign in_range = (req_addr_i >= BASE) && (word < ADDR_WIDTH'(NUM_WORDS));

    // Handshake: occupancy counts the in-flight slot plus queued responses
    logic       infl_valid_q, infl_we_q, infl_err_q;
    logic [1:0] count_q, count_d;
    logic       pop, push, accept;
    logic [2:0] occ;

    assign pop         = rsp_valid_o & rsp_ready_i;
    assign push        = infl_valid_q;
    assign occ         = 3'(count_q) + 3'(infl_valid_q) - 3'(pop);
    assign req_ready_o = rst_ni & (occ < 3'd2);
    assign accept      = req_valid_i & req_ready_o;

    // SRAM port, driven straight from the request in the accept cycle
    assign sram_req_o   = accept & in_range;
    assign sram_we_o    = sram_req_o & req_we_i;
    assign sram_be_o    = {BE_W{sram_req_o}} & req_be_i;
    assign sram_addr_o  = word[IDX_W-1:0];
    assign sram_wdata_o = req_wdata_i;

    // Response FIFO storage and pointers
    rsp_t fifo_q [2];
    logic wr_ptr_q, rd_ptr_q;
    rsp_t push_data;

    // Read data only exists for in-range reads
    always_comb begin
        push_data.err   = infl_err_q;
        push_data.rdata = '0;
        if (!infl_we_q && !infl_err_q) begin
            push_data.rdata = sram_rdata_i;
        end
    end

    // Occupancy next-state
    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 2'd1;
        end else if (!push && pop) begin
            count_d = count_q - 2'd1;
        end
    end

    // In-flight register: one cycle between SRAM strobe and data return
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            infl_valid_q <= 1'b0;
            infl_we_q    <= 1'b0;
            infl_err_q   <= 1'b0;
        end else begin
            infl_valid_q <= accept;
            infl_we_q    <= accept & req_we_i;
            infl_err_q   <= accept & ~in_range;
        end
    end

    // Response FIFO state
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < 2; i++) begin
                fifo_q[i] <= '0;
            end
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push) begin
                fifo_q[wr_ptr_q] <= push_data;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_d;
        end
    end

    // Head is gated so idle/reset outputs read as zero
    assign rsp_valid_o = (count_q != 2'd0);
    assign rsp_rdata_o = rsp_valid_o ? fifo_q[rd_ptr_q].rdata : '0;
    assign rsp_err_o   = rsp_valid_o & fifo_q[rd_ptr_q].err;

endmodule
